// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - sign-magnitude restoring divider, one quotient bit per clock
// Optional: `define DIVIDER_EARLY_EXIT_EN skips iteration when dividend_mag < |divisor|.
module seq_signed_divider #(
  parameter int DVD_W = 14,
  parameter int DVS_W = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend_mag,
  input  logic             dividend_sign,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient_mag,
  output logic             quotient_sign,
  output logic [DVS_W-1:0] remainder_mag,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t           state;
  logic [DVD_W-1:0] dvd_q;
  logic             sign_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   abs_q;
  logic [DVS_W:0]   prem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DVS_W:0]   dvs_ext;
  logic [DVS_W:0]   abs_comb;
  logic [DVS_W:0]   shift_rem;
  logic [DVS_W+1:0] trial;
  logic             no_borrow;
  logic [DVS_W:0]   next_rem;
  logic [DVD_W-1:0] next_q;
  logic             neg_q;
  logic             unused_prem_msb;

  // Extra bit lets |-2^(DVS_W-1)| be represented exactly.
  assign dvs_ext   = {dvs_q[DVS_W-1], dvs_q};
  assign abs_comb  = dvs_q[DVS_W-1] ? (~dvs_ext + 1'b1) : dvs_ext;

  assign shift_rem = {prem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
  assign trial     = {1'b0, shift_rem} - {1'b0, abs_q};
  assign no_borrow = ~trial[DVS_W+1];
  assign next_rem  = no_borrow ? trial[DVS_W:0] : shift_rem;
  assign next_q    = {dvd_q[DVD_W-2:0], no_borrow};
  assign neg_q     = sign_q ^ dvs_q[DVS_W-1];

  // Partial remainder stays below |divisor|, so its top bit never feeds the next shift.
  assign unused_prem_msb = prem_q[DVS_W];

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      dvd_q         <= '0;
      sign_q        <= 1'b0;
      dvs_q         <= '0;
      abs_q         <= '0;
      prem_q        <= '0;
      cnt_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient_mag  <= '0;
      quotient_sign <= 1'b0;
      remainder_mag <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_q       <= dividend_mag;
            sign_q      <= dividend_sign;
            dvs_q       <= divisor;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          abs_q <= abs_comb;
          if (dvs_q == '0) begin
            quotient_mag  <= '1;
            quotient_sign <= 1'b0;
            remainder_mag <= '0;
            div_by_zero   <= 1'b1;
            done          <= 1'b1;
            state         <= S_DONE;
          end
`ifdef DIVIDER_EARLY_EXIT_EN
          else if (dvd_q < DVD_W'(abs_comb)) begin
            quotient_mag  <= '0;
            quotient_sign <= 1'b0;
            remainder_mag <= dvd_q[DVS_W-1:0];
            done          <= 1'b1;
            state         <= S_DONE;
          end
`endif
          else begin
            prem_q <= '0;
            cnt_q  <= CNT_W'(DVD_W);
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          prem_q <= next_rem;
          dvd_q  <= next_q;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quotient_mag  <= next_q;
            quotient_sign <= neg_q & (|next_q);
            remainder_mag <= next_rem[DVS_W-1:0];
            done          <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - scoreboard bench for seq_signed_divider
module tb_seq_signed_divider;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] dividend_mag = '0;
  logic        dividend_sign = 1'b0;
  logic [7:0]  divisor = '0;
  logic        busy, done, quotient_sign, div_by_zero;
  logic [13:0] quotient_mag;
  logic [7:0]  remainder_mag;

  seq_signed_divider #(.DVD_W(14), .DVS_W(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start),
    .dividend_mag(dividend_mag), .dividend_sign(dividend_sign), .divisor(divisor),
    .busy(busy), .done(done), .quotient_mag(quotient_mag), .quotient_sign(quotient_sign),
    .remainder_mag(remainder_mag), .div_by_zero(div_by_zero)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [13:0] q;
    logic        qs;
    logic [7:0]  r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Reference: plain integer division on magnitudes, sign rules applied afterwards.
  task automatic push_exp(input logic [13:0] mag, input logic sg, input logic [7:0] dv, input int acc);
    exp_t e;
    int d, absd;
    d    = int'($signed(dv));
    absd = (d < 0) ? -d : d;
    e.acc = acc;
    if (absd == 0) begin
      e.q = 14'h3FFF; e.qs = 1'b0; e.r = 8'd0; e.dz = 1'b1; e.lat = 2;
    end else begin
      e.q  = 14'(int'(mag) / absd);
      e.r  = 8'(int'(mag) % absd);
      e.qs = (e.q != 0) && (sg ^ (d < 0));
      e.dz = 1'b0;
      e.lat = 16;
`ifdef DIVIDER_EARLY_EXIT_EN
      if (int'(mag) < absd) e.lat = 2;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(posedge sys_clk); #1;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [13:0] mag, input logic sg, input logic [7:0] dv);
    wait_idle();
    @(negedge sys_clk);
    dividend_mag = mag; dividend_sign = sg; divisor = dv; start = 1'b1;
    push_exp(mag, sg, dv, cyc + 1);
    @(posedge sys_clk); #1;
    start = 1'b0;
    dividend_mag = 14'($urandom); dividend_sign = 1'($urandom); divisor = 8'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk); #1;
      if (rst && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("quotient_mag", 32'(quotient_mag), 32'(e.q));
          chk("quotient_sign", 32'(quotient_sign), 32'(e.qs));
          chk("remainder_mag", 32'(remainder_mag), 32'(e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int done_seen;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'({quotient_sign, quotient_mag}), 32'd0);
    chk("rst_rem_dz", 32'({div_by_zero, remainder_mag}), 32'd0);
    @(negedge sys_clk); rst = 1'b1;

    issue(14'd1000, 1'b0, 8'd25);
    issue(14'd127, 1'b1, 8'hF9);
    issue(14'd16383, 1'b0, 8'h80);
    issue(14'd5, 1'b1, 8'd100);

    issue(14'd500, 1'b0, 8'h00);
    wait_idle();
    issue(14'd1000, 1'b0, 8'd25);
    chk("dz_clear_on_start", 32'(div_by_zero), 32'd0);
    chk("results_held_at_start", 32'(quotient_mag), 32'h3FFF);

    // Re-launch during ITER must be ignored.
    issue(14'd9999, 1'b1, 8'd13);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    dividend_mag = 14'd77; divisor = 8'd3; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;

    // Launch presented during the DONE cycle must be ignored.
    issue(14'd4321, 1'b0, 8'hF0);
    done_seen = 0;
    for (int i = 0; i < 40 && done_seen == 0; i++) begin
      @(posedge sys_clk); #1;
      if (done) done_seen = 1;
    end
    chk("done_seen_for_done_start", 32'(done_seen), 32'd1);
    dividend_mag = 14'd50; divisor = 8'd7; start = 1'b1;
    @(posedge sys_clk); #1; start = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 32'd0);

    // Reset mid-ITER aborts without a done pulse.
    issue(14'd12345, 1'b1, 8'd9);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk); rst = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'({quotient_sign, quotient_mag}), 32'd0);
    chk("abort_rem_dz", 32'({div_by_zero, remainder_mag}), 32'd0);
    @(negedge sys_clk); rst = 1'b1;
    issue(14'd1000, 1'b1, 8'd25);

    for (int i = 0; i < 40; i++) begin
      logic [13:0] m;
      logic [7:0]  d;
      m = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 300)) : 14'($urandom);
      d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      issue(m, 1'($urandom), d);
    end

    wait_idle();
    repeat (5) @(posedge sys_clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
